// File: rtl/buffer_pkg.sv
// buffer_pkg: shared constants and helpers for the buffer_core slice.
//   ORDER_FIFO / ORDER_FILO : legal values of the POP_ORDER parameter
//   count_width()           : occupancy counter width for a given depth
package buffer_pkg;

    localparam logic [31:0] ORDER_FIFO = "FIFO";
    localparam logic [31:0] ORDER_FILO = "FILO";

    // Occupancy runs 0..DEPTH inclusive, so one bit more than the address.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/buffer_storage.sv
// buffer_storage: DEPTH x DATA_WIDTH array, one write port, one registered
// read port. The array itself is never reset; only the read register is.
//   clk, rst         : clock, async active-high reset (read register only)
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request, data appears on rd_data after the edge
//   rd_data          : registered read data, holds when rd_en=0
module buffer_storage #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read-before-write: a same-address write on the same edge is not seen,
    // which is what the FILO replace-top case relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/buffer_core.sv
// buffer_core: parameterised FIFO/FILO buffer with occupancy flags and
// sticky overflow/underflow.
//   clk, rst_n           : clock; rst_n is async reset, asserted HIGH
//   clear                : synchronous flush (push/pop ignored that cycle)
//   push, push_data      : write request
//   pop                  : read request; pop_data/pop_valid one cycle later
//   count                : occupancy 0..DEPTH
//   full/empty/almost_*  : decoded from registered count only
//   overflow/underflow   : sticky until reset or clear
module buffer_core
    import buffer_pkg::*;
#(
    parameter int          DATA_WIDTH   = 8,
    parameter int          DEPTH        = 8,
    parameter logic [31:0] POP_ORDER    = ORDER_FIFO,
    parameter int          AFULL_LEVEL  = DEPTH - 1,
    parameter int          AEMPTY_LEVEL = 1
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic                          pop_valid,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam bit IS_FILO = (POP_ORDER == ORDER_FILO);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AE_LVL   = CW'(AEMPTY_LEVEL);

    if (POP_ORDER != ORDER_FIFO && POP_ORDER != ORDER_FILO) begin : g_bad_order
        $fatal(1, "buffer_core: POP_ORDER must be \"FIFO\" or \"FILO\"");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "buffer_core: DEPTH must be a power of two >= 2");
    end
    if (AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $fatal(1, "buffer_core: AFULL_LEVEL must not exceed DEPTH");
    end

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_addr, rd_addr, top_addr;
    logic          pop_acc, push_acc, do_pop, do_push;

    assign full         = (count == FULL_LVL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);
    assign do_pop   = pop_acc & ~clear;
    assign do_push  = push_acc & ~clear;

    // count-1 modulo DEPTH; only meaningful when count != 0, which is the
    // only time FILO reads it.
    assign top_addr = count[PW-1:0] - PW'(1);

    always_comb begin
        wr_addr = wr_ptr;
        rd_addr = rd_ptr;
        if (IS_FILO) begin
            rd_addr = top_addr;
            // Simultaneous push/pop replaces the top entry in place.
            wr_addr = pop_acc ? top_addr : count[PW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            pop_valid <= do_pop;
            if (push & ~push_acc) overflow  <= 1'b1;
            if (pop & empty)      underflow <= 1'b1;
        end
    end

    buffer_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk     (clk),
        .rst     (rst_n),
        .wr_en   (do_push),
        .wr_addr (wr_addr),
        .wr_data (push_data),
        .rd_en   (do_pop),
        .rd_addr (rd_addr),
        .rd_data (pop_data)
    );

endmodule

// File: tb/tb_buffer_core.sv
// tb_buffer_core: directed bench for buffer_core (DATA_WIDTH=8, DEPTH=8),
// one FIFO instance and one FILO instance sharing clock and reset.
module tb_buffer_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       f_clear = 0, f_push = 0, f_pop = 0;
    logic [7:0] f_pdata = 0, f_rdata;
    logic [3:0] f_count;
    logic       f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

    logic       s_clear = 0, s_push = 0, s_pop = 0;
    logic [7:0] s_pdata = 0, s_rdata;
    logic [3:0] s_count;
    logic       s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffer_core #(.DATA_WIDTH(8), .DEPTH(8), .POP_ORDER("FIFO")) u_fifo (
        .clk(clk), .rst_n(rst_n), .clear(f_clear), .push(f_push),
        .push_data(f_pdata), .pop(f_pop), .pop_data(f_rdata),
        .pop_valid(f_vld), .count(f_count), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf),
        .underflow(f_udf)
    );

    buffer_core #(.DATA_WIDTH(8), .DEPTH(8), .POP_ORDER("FILO")) u_filo (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .push(s_push),
        .push_data(s_pdata), .pop(s_pop), .pop_data(s_rdata),
        .pop_valid(s_vld), .count(s_count), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf),
        .underflow(s_udf)
    );

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic f_drive(input logic ps, input logic [7:0] d, input logic pp);
        f_push = ps; f_pdata = d; f_pop = pp;
        step();
        f_push = 0; f_pop = 0;
    endtask

    task automatic s_drive(input logic ps, input logic [7:0] d, input logic pp);
        s_push = ps; s_pdata = d; s_pop = pp;
        step();
        s_push = 0; s_pop = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #12;
        checks++;
        if (f_count !== 4'd0 || f_empty !== 1'b1 || f_full !== 1'b0 ||
            f_ae !== 1'b1 || f_af !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: count=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0",
                     f_count, f_empty, f_full, f_ae, f_af);
        end
        checks++;
        if (f_vld !== 1'b0 || f_rdata !== 8'h00 || f_ovf !== 1'b0 || f_udf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: vld=%b data=%h ovf=%b udf=%b want 0 00 0 0",
                     f_vld, f_rdata, f_ovf, f_udf);
        end
        @(negedge clk);
        rst_n = 1'b0;
        step();
    endtask

    task automatic test_fifo_order();
        for (int i = 1; i <= 8; i++) begin
            f_drive(1, 8'(i), 0);
            checks++;
            if (f_count !== 4'(i)) begin
                errors++;
                $display("FAIL fifo_push_count: got %0d want %0d", f_count, i);
            end
            if (i == 6) begin
                checks++;
                if (f_af !== 1'b0) begin
                    errors++; $display("FAIL afull_at_6: got %b want 0", f_af);
                end
            end
            if (i == 7) begin
                checks++;
                if (f_af !== 1'b1) begin
                    errors++; $display("FAIL afull_at_7: got %b want 1", f_af);
                end
            end
        end
        checks++;
        if (f_full !== 1'b1 || f_empty !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: full=%b empty=%b want 1 0", f_full, f_empty);
        end
        for (int i = 1; i <= 8; i++) begin
            f_drive(0, 8'h00, 1);
            checks++;
            if (f_vld !== 1'b1 || f_rdata !== 8'(i) || f_count !== 4'(8 - i)) begin
                errors++;
                $display("FAIL fifo_pop_%0d: vld=%b data=%h count=%0d want 1 %h %0d",
                         i, f_vld, f_rdata, f_count, 8'(i), 8 - i);
            end
            if (i == 6) begin
                checks++;
                if (f_ae !== 1'b0) begin
                    errors++; $display("FAIL aempty_at_2: got %b want 0", f_ae);
                end
            end
            if (i == 7) begin
                checks++;
                if (f_ae !== 1'b1) begin
                    errors++; $display("FAIL aempty_at_1: got %b want 1", f_ae);
                end
            end
        end
        checks++;
        if (f_empty !== 1'b1) begin
            errors++; $display("FAIL fifo_empty: got %b want 1", f_empty);
        end
        f_drive(0, 8'h00, 0);
        checks++;
        if (f_vld !== 1'b0 || f_rdata !== 8'h08) begin
            errors++;
            $display("FAIL fifo_hold: vld=%b data=%h want 0 08", f_vld, f_rdata);
        end
    endtask

    task automatic test_empty_push_pop();
        f_drive(1, 8'h99, 1);
        checks++;
        if (f_count !== 4'd1 || f_vld !== 1'b0 || f_udf !== 1'b1) begin
            errors++;
            $display("FAIL empty_pushpop: count=%0d vld=%b udf=%b want 1 0 1",
                     f_count, f_vld, f_udf);
        end
        f_drive(0, 8'h00, 1);
        checks++;
        if (f_vld !== 1'b1 || f_rdata !== 8'h99 || f_empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_pushpop_drain: vld=%b data=%h empty=%b want 1 99 1",
                     f_vld, f_rdata, f_empty);
        end
    endtask

    task automatic test_overflow_clear();
        for (int i = 0; i < 8; i++) f_drive(1, 8'(32'h30 + i), 0);
        checks++;
        if (f_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_before: got %b want 0", f_ovf);
        end
        f_drive(1, 8'h55, 0);
        checks++;
        if (f_ovf !== 1'b1 || f_count !== 4'd8) begin
            errors++;
            $display("FAIL overflow: ovf=%b count=%0d want 1 8", f_ovf, f_count);
        end
        f_drive(1, 8'h66, 1);
        checks++;
        if (f_vld !== 1'b1 || f_rdata !== 8'h30 || f_count !== 4'd8) begin
            errors++;
            $display("FAIL full_pushpop: vld=%b data=%h count=%0d want 1 30 8",
                     f_vld, f_rdata, f_count);
        end
        for (int i = 0; i < 3; i++) begin
            f_drive(0, 8'h00, 1);
            checks++;
            if (f_rdata !== 8'(32'h31 + i)) begin
                errors++;
                $display("FAIL drain_%0d: got %h want %h", i, f_rdata, 8'(32'h31 + i));
            end
        end
        checks++;
        if (f_count !== 4'd5 || f_ovf !== 1'b1 || f_udf !== 1'b1) begin
            errors++;
            $display("FAIL pre_clear: count=%0d ovf=%b udf=%b want 5 1 1",
                     f_count, f_ovf, f_udf);
        end
        f_clear = 1; f_push = 1; f_pdata = 8'hEE;
        step();
        f_clear = 0; f_push = 0;
        checks++;
        if (f_count !== 4'd0 || f_ovf !== 1'b0 || f_udf !== 1'b0 ||
            f_empty !== 1'b1 || f_vld !== 1'b0) begin
            errors++;
            $display("FAIL clear: count=%0d ovf=%b udf=%b empty=%b vld=%b want 0 0 0 1 0",
                     f_count, f_ovf, f_udf, f_empty, f_vld);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) f_drive(1, 8'(32'hA0 + i), 0);
        for (int i = 0; i < 20; i++) begin
            f_drive(1, 8'(32'hA3 + i), 1);
            checks++;
            if (f_vld !== 1'b1 || f_rdata !== 8'(32'hA0 + i) || f_count !== 4'd3) begin
                errors++;
                $display("FAIL wrap_%0d: vld=%b data=%h count=%0d want 1 %h 3",
                         i, f_vld, f_rdata, f_count, 8'(32'hA0 + i));
            end
        end
        for (int i = 0; i < 3; i++) begin
            f_drive(0, 8'h00, 1);
            checks++;
            if (f_rdata !== 8'(32'hB4 + i)) begin
                errors++;
                $display("FAIL wrap_drain_%0d: got %h want %h", i, f_rdata, 8'(32'hB4 + i));
            end
        end
    endtask

    task automatic test_filo();
        for (int i = 0; i < 4; i++) s_drive(1, 8'(32'h10 + i), 0);
        for (int i = 0; i < 4; i++) begin
            s_drive(0, 8'h00, 1);
            checks++;
            if (s_vld !== 1'b1 || s_rdata !== 8'(32'h13 - i)) begin
                errors++;
                $display("FAIL filo_pop_%0d: vld=%b data=%h want 1 %h",
                         i, s_vld, s_rdata, 8'(32'h13 - i));
            end
        end
        for (int i = 0; i < 4; i++) s_drive(1, 8'(32'h10 + i), 0);
        s_drive(1, 8'hAA, 1);
        checks++;
        if (s_vld !== 1'b1 || s_rdata !== 8'h13 || s_count !== 4'd4) begin
            errors++;
            $display("FAIL filo_replace: vld=%b data=%h count=%0d want 1 13 4",
                     s_vld, s_rdata, s_count);
        end
        s_drive(0, 8'h00, 1);
        checks++;
        if (s_rdata !== 8'hAA) begin
            errors++; $display("FAIL filo_new_top: got %h want aa", s_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            s_drive(0, 8'h00, 1);
            checks++;
            if (s_rdata !== 8'(32'h12 - i)) begin
                errors++;
                $display("FAIL filo_rest_%0d: got %h want %h", i, s_rdata, 8'(32'h12 - i));
            end
        end
        checks++;
        if (s_empty !== 1'b1) begin
            errors++; $display("FAIL filo_empty: got %b want 1", s_empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) f_drive(1, 8'(32'h40 + i), 0);
        checks++;
        if (f_count !== 4'd5) begin
            errors++; $display("FAIL pre_reset_count: got %0d want 5", f_count);
        end
        f_pop = 1;
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (f_count !== 4'd0 || f_vld !== 1'b0 || f_rdata !== 8'h00 ||
            f_empty !== 1'b1 || f_ae !== 1'b1 || f_full !== 1'b0 ||
            f_ovf !== 1'b0 || f_udf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d vld=%b data=%h empty=%b ae=%b full=%b",
                     f_count, f_vld, f_rdata, f_empty, f_ae, f_full);
        end
        f_pop = 0;
        rst_n = 1'b0;
        f_drive(1, 8'h77, 0);
        f_drive(0, 8'h00, 1);
        checks++;
        if (f_vld !== 1'b1 || f_rdata !== 8'h77 || f_count !== 4'd0) begin
            errors++;
            $display("FAIL post_reset: vld=%b data=%h count=%0d want 1 77 0",
                     f_vld, f_rdata, f_count);
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_empty_push_pop();
        test_overflow_clear();
        test_wrap();
        test_filo();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
